mem_access_stage: RTL and testbench

//  Pipeline stage 4: the memory-side responder to the execute stage's load/store requests.

---
 rtl/mem_access_stage_pkg.sv | 16 +
 rtl/mem_access_stage_if.sv | 32 +++
 rtl/mem_access_stage_data_ram.sv | 24 ++
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;

    // Memory-mapped LED register address (full 16-bit compare)
    localparam logic [WORD_W-1:0] MMIO_LED_ADDR = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Stage 3 -> stage 4 -> stage 5 signal bundle.
// master: the upstream/downstream side (execute stage plus writeback view).
// slave : the memory-access stage itself.
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic                  readEnable;
    logic                  writeEnable;
    logic [WORD_W-1:0]     Address;
    logic [WORD_W-1:0]     storeData;
    logic [WORD_W-1:0]     aluOutput;
    logic                  writeRegp3;
    logic [REG_ADDR_W-1:0] regAddressp3;

    logic                  stall;
    logic [WORD_W-1:0]     wbData;
    logic                  writeRegp4;
    logic [REG_ADDR_W-1:0] regAddressp4;

    modport master (
        output readEnable, writeEnable, Address, storeData, aluOutput,
               writeRegp3, regAddressp3,
        input  stall, wbData, writeRegp4, regAddressp4
    );

    modport slave (
        input  readEnable, writeEnable, Address, storeData, aluOutput,
               writeRegp3, regAddressp3,
        output stall, wbData, writeRegp4, regAddressp4
    );

endinterface

// File: rtl/mem_access_stage_data_ram.sv
// Single-port synchronous data RAM: one-cycle registered read, write enable,
// contents not reset.
module data_ram #(
    parameter int ADDR_BITS = 8,
    parameter int WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    // Write port plus registered read of the same index
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline stage 4: services load/store requests from the execute stage
// against a local word RAM with programmable wait states, stalling stage 3
// while busy, and forwards load data or the ALU result to writeback.
// Optional feature macro: MEM_MMIO_LED_EN adds the ledValue register mapped
// at MMIO_LED_ADDR.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  bus
`ifdef MEM_MMIO_LED_EN
    ,
    output logic [WORD_W-1:0]  ledValue
`endif
);

    // Wait counter preload; unused when WAIT_CYCLES is zero
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic                  w_req;
    logic                  w_stall;

    // Request latched in IDLE; stage 3 is free to change afterwards
    logic [ADDR_BITS-1:0]  r_idx;
    logic [WORD_W-1:0]     r_data;
    logic                  r_is_store;
    logic                  r_tag;
    logic [REG_ADDR_W-1:0] r_reg;
    logic                  r_mmio_hit;

    logic [WORD_W-1:0]     r_wb_data;
    logic                  r_write_regp4;
    logic [REG_ADDR_W-1:0] r_reg_addrp4;

    logic [ADDR_BITS-1:0]  w_ram_idx;
    logic                  w_ram_we;
    logic [WORD_W-1:0]     w_ram_rdata;
    logic [WORD_W-1:0]     w_load_data;

    assign w_req = bus.readEnable | bus.writeEnable;

    // Next-state and stall decode
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    w_state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_req) begin
                r_cnt <= WAIT_INIT;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Capture the request; a simultaneous read+write is kept as a store
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_req) begin
            r_idx      <= bus.Address[ADDR_BITS-1:0];
            r_data     <= bus.storeData;
            r_is_store <= bus.writeEnable;
            r_tag      <= bus.writeRegp3;
            r_reg      <= bus.regAddressp3;
`ifdef MEM_MMIO_LED_EN
            r_mmio_hit <= (bus.Address == MMIO_LED_ADDR);
`else
            r_mmio_hit <= 1'b0;
`endif
        end
    end

    // The RAM read is launched one edge before ACCESS so its registered
    // output is ready during ACCESS: in IDLE the live address is used, later
    // the latched one. Reset in ACCESS suppresses the write.
    assign w_ram_idx = (r_state == IDLE) ? bus.Address[ADDR_BITS-1:0] : r_idx;
    assign w_ram_we  = (r_state == ACCESS) && r_is_store && !r_mmio_hit && !rst;

    data_ram #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WORD_W)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_idx),
        .i_wdata (r_data),
        .o_rdata (w_ram_rdata)
    );

`ifdef MEM_MMIO_LED_EN
    logic [WORD_W-1:0] r_led;

    // LED register written by stores to MMIO_LED_ADDR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (r_state == ACCESS && r_is_store && r_mmio_hit) begin
            r_led <= r_data;
        end
    end

    assign ledValue    = r_led;
    assign w_load_data = r_mmio_hit ? r_led : w_ram_rdata;
`else
    assign w_load_data = w_ram_rdata;
`endif

    // Writeback outputs: pass-through in IDLE, bubbles while busy, load result in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_data     <= '0;
            r_write_regp4 <= 1'b0;
            r_reg_addrp4  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_write_regp4 <= 1'b0;
                    end else begin
                        r_wb_data     <= bus.aluOutput;
                        r_write_regp4 <= bus.writeRegp3;
                        r_reg_addrp4  <= bus.regAddressp3;
                    end
                end
                ACCESS: begin
                    if (r_is_store) begin
                        r_write_regp4 <= 1'b0;
                    end else begin
                        r_wb_data     <= w_load_data;
                        r_write_regp4 <= r_tag;
                        r_reg_addrp4  <= r_reg;
                    end
                end
                default: r_write_regp4 <= 1'b0;
            endcase
        end
    end

    assign bus.stall        = w_stall;
    assign bus.wbData       = r_wb_data;
    assign bus.writeRegp4   = r_write_regp4;
    assign bus.regAddressp4 = r_reg_addrp4;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: two instances (WAIT_CYCLES 0 and 3)
// each driven with directed plus random ops, checked against an array model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BOTH, K_RSTST, K_LEDCHK} kind_t;

    typedef struct {
        kind_t       kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] alu;
        logic        p3;
        logic [2:0]  rg;
    } op_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int W = (gi == 0) ? 0 : 3;

        logic rst;
        mem_access_stage_if sif();
`ifdef MEM_MMIO_LED_EN
        logic [15:0] led;
`endif

        mem_access_stage #(
            .ADDR_BITS   (8),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sif)
`ifdef MEM_MMIO_LED_EN
            ,
            .ledValue (led)
`endif
        );

        exp_t        exp_q [$];
        op_t         ops   [$];
        logic [15:0] model_mem [0:255];
        logic [15:0] led_m;

        // Monitor: every valid writeback must match the oldest expected result
        initial begin
            exp_t em;
            forever begin
                @(negedge clk);
                if (rst === 1'b0 && sif.writeRegp4 === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL w%0d mon_unexpected got wbData=%h reg=%0d want no writeback",
                                 W, sif.wbData, sif.regAddressp4);
                    end else begin
                        em = exp_q.pop_front();
                        if (sif.wbData !== em.data || sif.regAddressp4 !== em.rg) begin
                            failures++;
                            $display("FAIL w%0d mon_wb got data=%h reg=%0d want data=%h reg=%0d",
                                     W, sif.wbData, sif.regAddressp4, em.data, em.rg);
                        end
                    end
                end
            end
        end

        // Driver and reference model
        initial begin
            op_t   o;
            exp_t  e;
            int    n;
            int    exp_n;
            bit    lat_chk;
            bit    is_mem;

            rst = 1'b1;
            sif.readEnable = 1'b0; sif.writeEnable = 1'b0; sif.Address = '0;
            sif.storeData = '0; sif.aluOutput = '0; sif.writeRegp3 = 1'b0; sif.regAddressp3 = '0;
            led_m = '0;
            e.data = '0; e.rg = '0;

            // Build op list: prefill, directed cases, random mix
            for (int i = 0; i < 16; i++) begin
                o.kind = K_STORE; o.addr = 16'(i); o.alu = '0; o.p3 = 1'b0; o.rg = '0;
                o.data = {4'(i), 12'($urandom)};
                ops.push_back(o);
            end
            o = '{K_STORE, 16'h0012, 16'hBEEF, 16'h0000, 1'b0, 3'd0}; ops.push_back(o);
            o = '{K_LOAD,  16'h0012, 16'h0000, 16'h0000, 1'b1, 3'd5}; ops.push_back(o);
            o = '{K_ALU,   16'h0000, 16'h0000, 16'h0001, 1'b1, 3'd1}; ops.push_back(o);
            o = '{K_ALU,   16'h0000, 16'h0000, 16'h0002, 1'b1, 3'd2}; ops.push_back(o);
            o = '{K_ALU,   16'h0000, 16'h0000, 16'h0003, 1'b1, 3'd3}; ops.push_back(o);
            o = '{K_BOTH,  16'h0003, 16'h1234, 16'h0000, 1'b1, 3'd6}; ops.push_back(o);
            o = '{K_LOAD,  16'h0003, 16'h0000, 16'h0000, 1'b1, 3'd2}; ops.push_back(o);
            o = '{K_RSTST, 16'h0004, 16'hAAAA, 16'h0000, 1'b1, 3'd0}; ops.push_back(o);
            o = '{K_LOAD,  16'h0004, 16'h0000, 16'h0000, 1'b1, 3'd4}; ops.push_back(o);
`ifdef MEM_MMIO_LED_EN
            o = '{K_STORE,  16'hFF00, 16'h00C3, 16'h0000, 1'b0, 3'd0}; ops.push_back(o);
            o = '{K_LEDCHK, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0}; ops.push_back(o);
            o = '{K_LOAD,   16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd1}; ops.push_back(o);
            o = '{K_LOAD,   16'hFF00, 16'h0000, 16'h0000, 1'b1, 3'd7}; ops.push_back(o);
`endif
            for (int i = 0; i < 60; i++) begin
                o.kind = kind_t'($urandom_range(0, 3));
                o.addr = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
                o.data = 16'($urandom);
                o.alu  = 16'($urandom);
                o.p3   = ($urandom_range(0, 3) != 0);
                o.rg   = 3'($urandom);
                ops.push_back(o);
            end

            // Reset state
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++;
            if (sif.wbData !== 16'h0 || sif.writeRegp4 !== 1'b0 || sif.regAddressp4 !== 3'd0 || sif.stall !== 1'b0) begin
                failures++;
                $display("FAIL w%0d reset got wb=%h wr=%b reg=%0d stall=%b want all 0",
                         W, sif.wbData, sif.writeRegp4, sif.regAddressp4, sif.stall);
            end
            @(posedge clk); #1;
            rst = 1'b0;

            for (int k = 0; k < ops.size(); k++) begin
                o = ops[k];
                sif.readEnable   = (o.kind == K_LOAD || o.kind == K_BOTH);
                sif.writeEnable  = (o.kind == K_STORE || o.kind == K_BOTH || o.kind == K_RSTST);
                sif.Address      = o.addr;
                sif.storeData    = o.data;
                sif.aluOutput    = o.alu;
                sif.writeRegp3   = o.p3;
                sif.regAddressp3 = o.rg;
                is_mem  = (o.kind == K_LOAD || o.kind == K_STORE || o.kind == K_BOTH);
                exp_n   = is_mem ? W + 1 : 0;
                lat_chk = 1'b0;

                case (o.kind)
                    K_ALU: begin
                        if (o.p3) begin
                            e.data = o.alu; e.rg = o.rg;
                            exp_q.push_back(e);
                            lat_chk = 1'b1;
                        end
                    end
                    K_LOAD: begin
                        e.data = model_mem[o.addr[7:0]];
`ifdef MEM_MMIO_LED_EN
                        if (o.addr == MMIO_LED_ADDR) e.data = led_m;
`endif
                        e.rg = o.rg;
                        if (o.p3) begin
                            exp_q.push_back(e);
                            lat_chk = 1'b1;
                        end
                    end
                    K_STORE, K_BOTH: begin
`ifdef MEM_MMIO_LED_EN
                        if (o.addr == MMIO_LED_ADDR) led_m = o.data;
                        else model_mem[o.addr[7:0]] = o.data;
`else
                        model_mem[o.addr[7:0]] = o.data;
`endif
                    end
                    K_LEDCHK: begin
`ifdef MEM_MMIO_LED_EN
                        checks++;
                        if (led !== led_m) begin
                            failures++;
                            $display("FAIL w%0d ledValue got %h want %h", W, led, led_m);
                        end
`endif
                    end
                    default: ;
                endcase

                // Count stall cycles; every edge after the request edge is a bubble
                n = 0;
                forever begin
                    @(negedge clk);
                    if (n > 0) begin
                        checks++;
                        if (sif.writeRegp4 !== 1'b0) begin
                            failures++;
                            $display("FAIL w%0d bubble op%0d got writeRegp4=%b want 0", W, k, sif.writeRegp4);
                        end
                    end
                    if (sif.stall !== 1'b1) break;
                    n++;
                    if (n > 40) begin
                        failures++;
                        $display("FAIL w%0d stall_timeout op%0d got stall stuck want release", W, k);
                        break;
                    end
                    @(posedge clk); #1;
                end

                if (o.kind == K_RSTST) begin
                    // Reset lands in the ACCESS cycle of the store
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    sif.readEnable = 1'b0; sif.writeEnable = 1'b0; sif.writeRegp3 = 1'b0;
                    sif.aluOutput = '0; sif.regAddressp3 = '0;
                    checks++;
                    if (sif.wbData !== 16'h0 || sif.writeRegp4 !== 1'b0 || sif.regAddressp4 !== 3'd0) begin
                        failures++;
                        $display("FAIL w%0d rst_access got wb=%h wr=%b reg=%0d want all 0",
                                 W, sif.wbData, sif.writeRegp4, sif.regAddressp4);
                    end
                    @(posedge clk); #1;
                end else begin
                    checks++;
                    if (n != exp_n) begin
                        failures++;
                        $display("FAIL w%0d stall_cycles op%0d kind=%0d got %0d want %0d", W, k, o.kind, n, exp_n);
                    end
                    @(posedge clk); #1;
                    if (lat_chk) begin
                        checks++;
                        if (sif.writeRegp4 !== 1'b1 || sif.wbData !== e.data || sif.regAddressp4 !== e.rg) begin
                            failures++;
                            $display("FAIL w%0d latency op%0d got wr=%b data=%h reg=%0d want wr=1 data=%h reg=%0d",
                                     W, k, sif.writeRegp4, sif.wbData, sif.regAddressp4, e.data, e.rg);
                        end
                    end
                end
            end

            sif.readEnable = 1'b0; sif.writeEnable = 1'b0; sif.writeRegp3 = 1'b0;
            repeat (W + 4) @(posedge clk);
            @(negedge clk);
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL w%0d drain got %0d pending want 0", W, exp_q.size());
            end
            done[gi] = 1'b1;
        end
    end

    // Completion and summary
    initial begin
        int cyc;
        cyc = 0;
        while (!(done[0] && done[1]) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(done[0] && done[1])) begin
            checks++;
            failures++;
            $display("FAIL run_timeout got done=%b%b want 11", done[1], done[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
